// File: rtl/signed_approx_mult_if.sv
// Operand/result bundle for the signed approximate multiplier.
// master drives in_valid/A/B and receives out_valid/out; slave is the multiplier side.
interface signed_approx_mult_if #(
    parameter int WIDTH = 16
);
    logic                      in_valid;
    logic signed [WIDTH-1:0]   A;
    logic signed [WIDTH-1:0]   B;
    logic                      out_valid;
    logic signed [2*WIDTH-1:0] out;

    modport master (
        output in_valid,
        output A,
        output B,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output out_valid,
        output out
    );
endinterface

// File: rtl/signed_approx_mult.sv
// Signed WIDTHxWIDTH approximate multiplier, sign-magnitude, 2-cycle pipeline.
// Ports: clk, rst_n (async low), bus (slave: in_valid, A, B -> out_valid, out).
module signed_approx_mult #(
    parameter int WIDTH       = 16,
    parameter int APPROX_COLS = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    signed_approx_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    // Columns at or above APPROX_COLS are summed exactly; the rest are OR'd.
    localparam logic [PW-1:0] ONE        = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] UPPER_MASK = ~((ONE << APPROX_COLS) - ONE);

    logic             s1_valid;
    logic             s1_sign;
    logic [WIDTH-1:0] s1_ma;
    logic [WIDTH-1:0] s1_mb;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [PW-1:0] row;
    logic [PW-1:0] upper_sum;
    logic [PW-1:0] lower_or;
    logic [PW-1:0] mag;

    logic          out_valid_q;
    logic [PW-1:0] out_q;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        a_mag = bus.A[WIDTH-1] ? (~$unsigned(bus.A) + 1'b1) : $unsigned(bus.A);
        b_mag = bus.B[WIDTH-1] ? (~$unsigned(bus.B) + 1'b1) : $unsigned(bus.B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                s1_ma   <= a_mag;
                s1_mb   <= b_mag;
            end
        end
    end

    // Each row holds one multiplicand bit's partial products, already shifted
    // into its columns. Masked OR of rows gives the per-column OR for the
    // approximate part; masked sum of rows gives the exact upper part with
    // no carry coming up from the low columns.
    always_comb begin
        row       = '0;
        upper_sum = '0;
        lower_or  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row       = {{WIDTH{1'b0}}, s1_mb & {WIDTH{s1_ma[i]}}} << i;
            upper_sum = upper_sum + (row & UPPER_MASK);
            lower_or  = lower_or | (row & ~UPPER_MASK);
        end
        mag = upper_sum + lower_or;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                // Negating zero yields zero, so the sign needs no special case.
                out_q <= s1_sign ? (~mag + ONE) : mag;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = $signed(out_q);
endmodule

// File: tb/tb_signed_approx_mult.sv
// Scoreboard bench for signed_approx_mult at APPROX_COLS=8 and APPROX_COLS=0.
// Column-count reference model, randomized stimulus with valid gaps and resets.
module tb_signed_approx_mult;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               in_valid;
    logic signed [15:0] a_in;
    logic signed [15:0] b_in;

    signed_approx_mult_if #(.WIDTH(16)) if8 ();
    signed_approx_mult_if #(.WIDTH(16)) if0 ();

    assign if8.in_valid = in_valid;
    assign if8.A        = a_in;
    assign if8.B        = b_in;
    assign if0.in_valid = in_valid;
    assign if0.A        = a_in;
    assign if0.B        = b_in;

    signed_approx_mult #(.WIDTH(16), .APPROX_COLS(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    signed_approx_mult #(.WIDTH(16), .APPROX_COLS(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    typedef struct {
        logic signed [31:0] exp;
        int                 a;
        int                 b;
    } exp_t;

    exp_t q8[$];
    exp_t q0[$];
    logic signed [31:0] last8 = '0;
    logic signed [31:0] last0 = '0;

    int ncmp = 0;
    int nbad = 0;

    task automatic cmp(input string name, input longint act, input longint req);
        ncmp++;
        if (act != req) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Count the partial-product bits in every column, then weigh the
    // columns: OR'd (0/1) below ac, full count at and above ac.
    function automatic logic signed [31:0] model(input int a, input int b, input int ac);
        longint ma;
        longint mb;
        longint p;
        int     cnt[64];
        ma = (a < 0) ? -longint'(a) : longint'(a);
        mb = (b < 0) ? -longint'(b) : longint'(b);
        p  = 0;
        for (int j = 0; j < 64; j++) cnt[j] = 0;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 16; k++)
                if (ma[i] && mb[k]) cnt[i+k]++;
        for (int j = 0; j < 32; j++) begin
            if (j < ac) p += (cnt[j] != 0) ? (longint'(1) << j) : 0;
            else        p += longint'(cnt[j]) << j;
        end
        if ((a < 0) != (b < 0)) p = -p;
        return 32'(p);
    endfunction

    task automatic drive(input logic v, input int a, input int b, input logic signed [31:0] e8);
        @(posedge clk);
        #1;
        in_valid = v;
        a_in     = 16'(a);
        b_in     = 16'(b);
        if (v) begin
            q8.push_back('{e8, a, b});
            q0.push_back('{32'(a * b), a, b});
        end
    endtask

    task automatic send_model(input int a, input int b);
        drive(1'b1, a, b, model(a, b, 8));
    endtask

    task automatic idle();
        drive(1'b0, int'($signed(16'($urandom()))), int'($signed(16'($urandom()))), '0);
    endtask

    task automatic chk(input int which, input logic ov, input logic signed [31:0] o);
        exp_t   e;
        longint ao;
        longint ap;
        string  tag;
        tag = (which == 8) ? "ac8" : "ac0";
        if (ov) begin
            if ((which == 8 && q8.size() == 0) || (which == 0 && q0.size() == 0)) begin
                ncmp++;
                nbad++;
                $display("FAIL %s_spurious_valid: got out_valid=1 out=%0d, expected no result", tag, o);
                return;
            end
            if (which == 8) begin
                e = q8.pop_front();
                last8 = e.exp;
            end else begin
                e = q0.pop_front();
                last0 = e.exp;
            end
            cmp({tag, "_value"}, longint'(o), longint'(e.exp));
            ao = (o < 0) ? -longint'(o) : longint'(o);
            ap = longint'(e.a) * longint'(e.b);
            if (ap < 0) ap = -ap;
            cmp({tag, "_bound"}, longint'(ao <= ap), 1);
            if (o != 0)
                cmp({tag, "_sign"}, longint'(o < 0),
                    longint'((longint'(e.a) * longint'(e.b)) < 0));
        end else begin
            cmp({tag, "_hold"}, longint'(o), (which == 8) ? longint'(last8) : longint'(last0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk(8, if8.out_valid, if8.out);
            chk(0, if0.out_valid, if0.out);
        end
    end

    task automatic check_reset_state(input string name);
        cmp({name, "_out8"}, longint'(if8.out), 0);
        cmp({name, "_vld8"}, longint'(if8.out_valid), 0);
        cmp({name, "_out0"}, longint'(if0.out), 0);
        cmp({name, "_vld0"}, longint'(if0.out_valid), 0);
    endtask

    initial begin
        int a;
        int b;
        int waited;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom());
            a_in     = 16'($urandom());
            b_in     = 16'($urandom());
            #3;
            check_reset_state("reset_hold");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed values for the approximate instance
        drive(1'b1, 0, -1234, 0);
        drive(1'b1, 1, 1, 1);
        drive(1'b1, 3, 3, 7);
        drive(1'b1, -3, 3, -7);
        drive(1'b1, 255, 255, 63487);
        drive(1'b1, -255, 255, -63487);
        drive(1'b1, 256, 256, 65536);
        drive(1'b1, -32768, -32768, 1073741824);
        drive(1'b1, -32768, 1, -32768);
        idle();
        idle();
        idle();

        // Three back-to-back operands
        send_model(-12755, 32229);
        send_model(9975, -10051);
        send_model(-2109, -208);
        idle();
        idle();
        idle();

        // Asynchronous reset mid-cycle with data in flight
        send_model(12345, -321);
        send_model(-7, 9999);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_async");
        q8.delete();
        q0.delete();
        last8    = '0;
        last0    = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        send_model(-1, -1);
        send_model(32767, -32768);
        idle();

        // Random vectors with valid gaps, edge operands mixed in
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            case ($urandom_range(0, 9))
                0:       a = -32768;
                1:       a = 0;
                2:       a = int'($signed(16'($urandom_range(0, 15) - 8)));
                default: a = int'($signed(16'($urandom())));
            endcase
            case ($urandom_range(0, 9))
                0:       b = -32768;
                1:       b = 32767;
                default: b = int'($signed(16'($urandom())));
            endcase
            send_model(a, b);
        end
        idle();

        waited = 0;
        while ((q8.size() != 0 || q0.size() != 0) && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        ncmp++;
        if (q8.size() != 0 || q0.size() != 0) begin
            nbad++;
            $display("FAIL drain_timeout: got %0d/%0d results outstanding, expected 0",
                     q8.size(), q0.size());
        end
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
